apb4_master_engine: RTL

- Synthesizable, parametrised APB4 master. Accepts transfer requests over a valid/ready command port, buffers them in a command FIFO, and executes each as a protocol-compliant APB4 SETUP/ACCESS sequence.
- Returns read data and error/timeout status on a valid/ready response port.
- Sits between an in-house controller (DMA, debug bridge, CPU shim) and an APB4 peripheral bus.
- Generalises the bench-only APB4 master:
  - configurable widths;
  - per-transfer strobe and protection;
  - queued back-to-back transfers;
  - PSLVERR capture;
  - ACCESS-phase timeout.

---
 rtl/apb4_master_engine.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/apb4_master_engine.sv
`default_nettype none
// ============================================================================
// Module  : apb4_master_engine
// Brief   : Queued APB4 master with valid/ready command and response ports.
// Revision: 1.0 - initial release
// ============================================================================
module apb4_master_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_ptr_w  = $clog2(CMD_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_tw     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(CMD_DEPTH);
    localparam logic [c_tw-1:0]    c_tlim  = c_tw'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic                  r_rst_done;
    logic [c_tw-1:0]       r_tcnt;

    logic                  r_mem_write [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_wdata [CMD_DEPTH];
    logic [c_strb_w-1:0]   r_mem_strb  [CMD_DEPTH];
    logic [2:0]            r_mem_prot  [CMD_DEPTH];

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [c_strb_w-1:0]   r_pstrb;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_fifo_ne;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tmo;
    logic                  w_done;

    assign w_fifo_ne = (r_count != '0);
    assign w_push    = req_valid_i && req_ready_o;
    // A new transfer is launched from IDLE, or straight out of RESP on handshake.
    assign w_pop     = w_fifo_ne && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready_i));
    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !pready_i && (r_tcnt == c_tlim);
    assign w_done    = (r_state == S_ACCESS) && pready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_fifo_ne) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: if (pready_i || w_tmo) w_next_state = S_RESP;
            S_RESP:   if (rsp_ready_i) w_next_state = w_fifo_ne ? S_SETUP : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_write[r_wptr] <= req_write_i;
            r_mem_addr[r_wptr]  <= req_addr_i;
            r_mem_wdata[r_wptr] <= req_wdata_i;
            r_mem_strb[r_wptr]  <= req_strb_i;
            r_mem_prot[r_wptr]  <= req_prot_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rst_done <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end else if (w_pop) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= r_mem_write[r_rptr];
            r_paddr   <= r_mem_addr[r_rptr];
            r_pprot   <= r_mem_prot[r_rptr];
            r_pwdata  <= r_mem_write[r_rptr] ? r_mem_wdata[r_rptr] : '0;
            r_pstrb   <= r_mem_write[r_rptr] ? r_mem_strb[r_rptr]  : '0;
        end else if (r_state == S_SETUP) begin
            r_penable <= 1'b1;
        end else if (w_done || w_tmo) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end
    end

    // Counts ACCESS cycles that saw pready low; cleared everywhere else.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tcnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready_i && !w_tmo) begin
            r_tcnt <= r_tcnt + c_tw'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata_i;
            r_rsp_err     <= pslverr_i;
            r_rsp_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end
    end

    assign req_ready_o   = r_rst_done && (r_count != c_depth);
    assign busy_o        = w_fifo_ne || (r_state != S_IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign paddr_o       = r_paddr;
    assign pprot_o       = r_pprot;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;

endmodule
`default_nettype wire
